// File: rtl/axi4_lite_pkg.sv
// Shared types and decode helpers for the AXI4-Lite register file slave.
// Response codes, channel FSM states and address-decode width functions.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic int lsb_f(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int idx_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational AXI4-Lite address decode: byte address to word index,
// in-range flag and read-only flag.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  localparam int                IDX_W      = idx_w_f(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  ro
);

  localparam int LSB = lsb_f(DATA_WIDTH);

  // Byte-offset and high address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign idx = addr[LSB +: IDX_W];

  always_comb begin
    in_range = 1'b0;
    ro       = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        in_range = 1'b1;
        ro       = RO_MASK[i];
      end
    end
  end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave terminating all five channels into a register bank
// with byte strobes, hardware-sourced read-only registers and write pulses.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_w_f(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [2:0]            awprot_q, awprot_d;
  logic [2:0]            arprot_q, arprot_d;
  resp_t                 bresp_q, bresp_d;
  resp_t                 rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  logic                  aw_inr, aw_ro, ar_inr, ar_ro;

  // Protection bits are recorded but grant no access rights.
  logic unused_prot;
  assign unused_prot = ^{awprot_q, arprot_q};

  // Readies held low on the reset cycle itself.
  assign AWREADY = ~ARESET & ((wr_q == W_IDLE) | (wr_q == W_GOT_W));
  assign WREADY  = ~ARESET & ((wr_q == W_IDLE) | (wr_q == W_GOT_AW));
  assign ARREADY = ~ARESET & (rd_q == R_IDLE);
  assign BVALID  = (wr_q == W_RESP);
  assign RVALID  = (rd_q == R_RESP);
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign reg_q   = regs_q;
  assign wr_pulse = pulse_q;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  assign aw_addr = (wr_q == W_GOT_AW) ? awaddr_q : AWADDR;
  assign w_data  = (wr_q == W_GOT_W) ? wdata_q : WDATA;
  assign w_strb  = (wr_q == W_GOT_W) ? wstrb_q : WSTRB;

  axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_aw_dec (
    .addr     (aw_addr),
    .idx      (aw_idx),
    .in_range (aw_inr),
    .ro       (aw_ro)
  );

  axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_ar_dec (
    .addr     (ARADDR),
    .idx      (ar_idx),
    .in_range (ar_inr),
    .ro       (ar_ro)
  );

  always_comb begin
    wr_d     = wr_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    awprot_d = awprot_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    pulse_d  = '0;
    commit   = 1'b0;
    unique case (wr_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          awprot_d = AWPROT;
        end else if (aw_hs) begin
          awaddr_d = AWADDR;
          awprot_d = AWPROT;
          wr_d     = W_GOT_AW;
        end else if (w_hs) begin
          wdata_d = WDATA;
          wstrb_d = WSTRB;
          wr_d    = W_GOT_W;
        end
      end
      W_GOT_AW: commit = w_hs;
      W_GOT_W: begin
        if (aw_hs) begin
          commit   = 1'b1;
          awprot_d = AWPROT;
        end
      end
      W_RESP: if (BREADY) wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
    if (commit) begin
      wr_d = W_RESP;
      if (!aw_inr) begin
        bresp_d = RESP_DECERR;
      end else if (aw_ro) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IDX_W'(i)) begin
            pulse_d[i] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs_d[i][b*8 +: 8] = w_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge commit is not yet visible.
  always_comb begin
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    arprot_d = arprot_q;
    unique case (rd_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_d     = R_RESP;
          arprot_d = ARPROT;
          rdata_d  = '0;
          rresp_d  = ar_inr ? RESP_OKAY : RESP_DECERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_inr && ar_idx == IDX_W'(i)) begin
              rdata_d = ar_ro ? hw_in[i*DATA_WIDTH +: DATA_WIDTH]
                              : regs_q[i];
            end
          end
        end
      end
      R_RESP: if (RREADY) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_q     <= W_IDLE;
      rd_q     <= R_IDLE;
      regs_q   <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awprot_q <= '0;
      arprot_q <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      pulse_q  <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      regs_q   <= regs_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      awprot_q <= awprot_d;
      arprot_q <= arprot_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed self-checking bench for axi4_lite_regfile_slave.
// 12 registers, register 1 read-only from hw_in.
module tb_axi4_lite_regfile_slave;

  localparam int NR = 12;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [AW-1:0]     AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [DW-1:0]     WDATA;
  logic [DW/8-1:0]   WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [AW-1:0]     ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [NR*DW-1:0]  reg_q;
  logic [NR*DW-1:0]  hw_in;
  logic [NR-1:0]     wr_pulse;

  axi4_lite_regfile_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (12'h002)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .AWADDR   (AWADDR),
    .AWPROT   (AWPROT),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .ARADDR   (ARADDR),
    .ARPROT   (ARPROT),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .reg_q    (reg_q),
    .hw_in    (hw_in),
    .wr_pulse (wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] m [NR];

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] mflat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m[i];
    return r;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] rsp,
                    input logic [NR-1:0] pls, input string tag);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check({tag, "_bvalid"}, BVALID, 1);
    check({tag, "_bresp"}, BRESP, rsp);
    check({tag, "_pulse"}, wr_pulse, pls);
    check({tag, "_regs"}, reg_q == mflat(), 1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check({tag, "_bdone"}, BVALID, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] rsp, input string tag);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    check({tag, "_rvalid"}, RVALID, 1);
    check({tag, "_rdata"}, RDATA, d);
    check({tag, "_rresp"}, RRESP, rsp);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check({tag, "_rdone"}, RVALID, 0);
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWPROT = 3'b010; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = 32'hBAD0_0000 | i;
    hw_in[1*DW +: DW] = 32'hCAFE_0001;
    for (int i = 0; i < NR; i++) m[i] = '0;

    tick();
    tick();
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_pulse", wr_pulse, 0);
    check("rst_regs", |reg_q, 0);
    ARESET = 1'b0;
    tick();
    check("post_awready", AWREADY, 1);
    check("post_wready", WREADY, 1);
    check("post_arready", ARREADY, 1);

    m[2] = 32'hDEAD_BEEF;
    wr(32'h8, 32'hDEAD_BEEF, 4'hF, 2'b00, 12'h004, "w1");
    rd(32'h8, 32'hDEAD_BEEF, 2'b00, "r1");

    m[2] = 32'hDE22_BE44;
    wr(32'h8, 32'h1122_3344, 4'h5, 2'b00, 12'h004, "strb");

    WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("wl_wready", WREADY, 0);
    check("wl_awready", AWREADY, 1);
    check("wl_bvalid", BVALID, 0);
    tick();
    tick();
    check("wl_nocommit", reg_q == mflat(), 1);
    AWADDR = 32'hC; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    m[3] = 32'hA5A5_A5A5;
    check("wl_bvalid1", BVALID, 1);
    check("wl_pulse", wr_pulse, 12'h008);
    check("wl_regs", reg_q == mflat(), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_bvalid", BVALID, 1);
      check("hold_bresp", BRESP, 0);
      check("hold_awready", AWREADY, 0);
      check("hold_wready", WREADY, 0);
      check("hold_pulse", wr_pulse, 0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("wl_bdone", BVALID, 0);

    wr(32'h4, 32'h1234_5678, 4'hF, 2'b10, 12'h000, "ro");
    rd(32'h4, 32'hCAFE_0001, 2'b00, "ro_rd");
    rd(32'hC, 32'hA5A5_A5A5, 2'b00, "rw_rd");

    wr(32'h14, 32'hFFFF_FFFF, 4'h0, 2'b00, 12'h020, "strb0");

    rd(32'h30, 32'h0, 2'b11, "oor_rd");
    wr(32'h30, 32'h1234, 4'hF, 2'b11, 12'h000, "oor_wr");
    rd(32'h4B, 32'hDE22_BE44, 2'b00, "alias");

    AWADDR = 32'h8; WDATA = 32'h0; WSTRB = 4'hF;
    ARADDR = 32'h8;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    m[2] = 32'h0;
    check("se_rvalid", RVALID, 1);
    check("se_rdata", RDATA, 32'hDE22_BE44);
    check("se_bvalid", BVALID, 1);
    check("se_regs", reg_q == mflat(), 1);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;

    AWADDR = 32'h14; AWVALID = 1'b1;
    ARADDR = 32'hC; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    check("mr_awready", AWREADY, 0);
    check("mr_wready", WREADY, 1);
    check("mr_rvalid", RVALID, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) m[i] = '0;
    check("mr_bvalid", BVALID, 0);
    check("mr_rvalid0", RVALID, 0);
    check("mr_awready1", AWREADY, 1);
    check("mr_wready1", WREADY, 1);
    check("mr_arready1", ARREADY, 1);
    check("mr_regs", reg_q == mflat(), 1);
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("mr_w_bvalid", BVALID, 0);
    check("mr_w_pulse", wr_pulse, 0);
    check("mr_w_regs", reg_q == mflat(), 1);
    check("mr_w_awready", AWREADY, 1);
    check("mr_w_wready", WREADY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
